// File: rtl/apb_cfg_slave.sv
// rtl/apb_cfg_slave.sv - APB completer driving a bank of configuration registers
// with optional pready wait states, pslverr decode and a sticky protocol-error flag.
module apb_cfg_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 24,
    parameter int NUM_REGS = 58,
    parameter int WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           pclk,
    input  logic                           reset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_out,
    output logic [NUM_REGS-1:0]            wr_strobe,
    output logic                           proto_err
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    dir_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    oor_q;
    logic [3:0]              cnt;
    logic [DATA_WIDTH-1:0]   rd_mux;
    logic                    oor;
    logic                    bus_changed;
    logic                    violation;

    // Full-width decode: anything at or above NUM_REGS is an error, no aliasing.
    assign oor = ({1'b0, paddr} >= (ADDR_WIDTH+1)'(NUM_REGS));

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (paddr == ADDR_WIDTH'(i)) rd_mux = regs[i];
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
            assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    endgenerate

    // Only a master still in its access phase must hold the bus; a new setup phase may change it.
    assign bus_changed = psel && penable &&
                         (paddr != addr_q || pwrite != dir_q || pwdata != data_q);

    assign violation = (penable && !psel) ||
                       (state == IDLE && penable) ||
                       (state == ACCESS && bus_changed) ||
                       (state == ACCESS && !pready && !psel);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            dir_q     <= 1'b0;
            data_q    <= '0;
            oor_q     <= 1'b0;
            prdata    <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            wr_strobe <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_strobe <= '0;
            if (violation) proto_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (psel && !penable) state <= SETUP;
                end
                SETUP: begin
                    state   <= ACCESS;
                    addr_q  <= paddr;
                    dir_q   <= pwrite;
                    data_q  <= pwdata;
                    oor_q   <= oor;
                    cnt     <= 4'(WAIT_STATES);
                    prdata  <= rd_mux;
                    pready  <= (WAIT_STATES == 0);
                    pslverr <= (WAIT_STATES == 0) && oor;
                end
                ACCESS: begin
                    if (!pready) begin
                        if (!psel) begin
                            state   <= IDLE;
                            pready  <= 1'b0;
                            pslverr <= 1'b0;
                        end else begin
                            cnt <= cnt - 4'd1;
                            if (cnt == 4'd1) begin
                                pready  <= 1'b1;
                                pslverr <= oor_q;
                            end
                        end
                    end else begin
                        if (dir_q && !oor_q) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr_q == ADDR_WIDTH'(i)) begin
                                    regs[i]      <= data_q;
                                    wr_strobe[i] <= 1'b1;
                                end
                            end
                        end
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        state   <= (psel && !penable) ? SETUP : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cfg_slave.sv
// tb/tb_apb_cfg_slave.sv - randomized bench for apb_cfg_slave with a transaction-level model;
// instance 0 runs with no wait states, instance 1 with three.
module tb_apb_cfg_slave;
    localparam int NR = 58;
    localparam int DW = 24;

    logic              pclk = 1'b0;
    logic              reset;
    logic              psel [2];
    logic              penable [2];
    logic              pwrite [2];
    logic [7:0]        paddr [2];
    logic [DW-1:0]     pwdata [2];
    logic [DW-1:0]     prdata [2];
    logic              pready [2];
    logic              pslverr [2];
    logic [NR*DW-1:0]  cfg [2];
    logic [NR-1:0]     strb [2];
    logic              perr [2];

    logic [DW-1:0]     mreg [2][NR];
    logic [NR-1:0]     exp_strobe [2];
    int                strobe_cyc [2];
    logic              exp_perr [2];
    int                cyc = 0;
    int                checks = 0;
    int                failures = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_cfg_slave #(.WAIT_STATES(0)) u0 (
        .pclk(pclk), .reset(reset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .cfg_out(cfg[0]), .wr_strobe(strb[0]), .proto_err(perr[0]));

    apb_cfg_slave #(.WAIT_STATES(3)) u3 (
        .pclk(pclk), .reset(reset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .cfg_out(cfg[1]), .wr_strobe(strb[1]), .proto_err(perr[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NR; i++) mreg[d][i] = '0;
            exp_strobe[d] = '0;
            strobe_cyc[d] = -1;
            exp_perr[d]   = 1'b0;
        end
    endtask

    task automatic bus_idle(input int d);
        psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    endtask

    task automatic commit(input int d, input logic [7:0] a, input logic [DW-1:0] v);
        if (a < NR) begin
            mreg[d][a]    = v;
            exp_strobe[d] = NR'(1) << a;
            strobe_cyc[d] = cyc;
        end
    endtask

    // Standard APB master transfer; entered and left just after a rising edge.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [DW-1:0] v,
                        output int waits, output logic [DW-1:0] rd, output logic err);
        int ws;
        logic [DW-1:0] exp_rd;
        ws = (d == 0) ? 0 : 3;
        exp_rd = (a < NR) ? mreg[d][a] : '0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = v;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge pclk);
            if (pready[d] === 1'b1 || waits > 40) break;
            waits++;
        end
        chk($sformatf("latency dut%0d", d), waits, 1 + ws);
        rd  = prdata[d];
        err = pslverr[d];
        chk($sformatf("pslverr dut%0d a=%0d", d, a), err, (a >= NR));
        if (!wr) chk($sformatf("prdata dut%0d a=%0d", d, a), rd, exp_rd);
        @(posedge pclk); #1;
        if (wr) commit(d, a, v);
        bus_idle(d);
    endtask

    task automatic reset_state_checks(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, " prdata"}, prdata[d], 0);
            chk({tag, " pready"}, pready[d], 0);
            chk({tag, " pslverr"}, pslverr[d], 0);
            chk({tag, " wr_strobe"}, strb[d], 0);
            chk({tag, " proto_err"}, perr[d], 0);
            chk({tag, " cfg_nonzero"}, |cfg[d], 0);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge pclk);
            for (int d = 0; d < 2; d++) begin
                int bad;
                bad = -1;
                for (int i = 0; i < NR; i++) if (cfg[d][i*DW +: DW] !== mreg[d][i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    failures++;
                    $display("FAIL cfg_out dut%0d reg%0d actual=%0h expected=%0h",
                             d, bad, cfg[d][bad*DW +: DW], mreg[d][bad]);
                end
                chk($sformatf("wr_strobe dut%0d", d), strb[d],
                    (strobe_cyc[d] == cyc) ? exp_strobe[d] : NR'(0));
                chk($sformatf("proto_err dut%0d", d), perr[d], exp_perr[d]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        logic [DW-1:0] rd, v;
        logic e;
        logic [7:0] a;
        logic [DW-1:0] b2b_data [3];

        reset = 1'b1;
        bus_idle(0); bus_idle(1);
        model_clear();
        fork compare_loop(); join_none
        repeat (2) @(posedge pclk);
        #1 reset_state_checks("por");
        reset = 1'b0;
        @(posedge pclk); #1;

        // Write reg5 with no wait states, then pin literal results.
        xfer(0, 1'b1, 8'd5, 24'hA5A5A5, w, rd, e);
        chk("t2 latency", w, 1);
        chk("t2 pslverr", e, 0);
        @(negedge pclk);
        chk("t2 reg5", cfg[0][5*DW +: DW], 24'hA5A5A5);
        chk("t2 strobe", strb[0], 58'h20);
        @(posedge pclk); #1;

        // Three wait states: write then read back reg5.
        xfer(1, 1'b1, 8'd5, 24'hA5A5A5, w, rd, e);
        xfer(1, 1'b0, 8'd5, 24'h0, w, rd, e);
        chk("t3 waits", w, 4);
        chk("t3 prdata", rd, 24'hA5A5A5);
        chk("t3 pslverr", e, 0);

        // Out-of-range write.
        xfer(0, 1'b1, 8'd58, 24'h123456, w, rd, e);
        chk("t4 pslverr", e, 1);
        @(negedge pclk);
        chk("t4 no strobe", strb[0], 0);
        @(posedge pclk); #1;

        // Randomized traffic on both instances.
        for (int n = 0; n < 60; n++) begin
            int d;
            d = $urandom_range(0, 1);
            a = ($urandom_range(0, 99) < 85) ? 8'($urandom_range(0, NR-1)) : 8'($urandom_range(NR, 255));
            v = DW'($urandom);
            xfer(d, 1'($urandom_range(0, 1)), a, v, w, rd, e);
            repeat ($urandom_range(0, 2)) begin @(posedge pclk); #1; end
        end

        // Fixed-cadence back-to-back writes to regs 0,1,2: six master cycles, no idle gap.
        for (int k = 0; k < 3; k++) b2b_data[k] = DW'($urandom);
        for (int k = 0; k < 3; k++) begin
            psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
            paddr[0] = 8'(k); pwdata[0] = b2b_data[k];
            @(negedge pclk);
            chk($sformatf("b2b ready setup%0d", k), pready[0], (k > 0));
            @(posedge pclk); #1;
            if (k > 0) commit(0, 8'(k-1), b2b_data[k-1]);
            penable[0] = 1'b1;
            @(negedge pclk);
            chk($sformatf("b2b ready access%0d", k), pready[0], 0);
            @(posedge pclk); #1;
        end
        bus_idle(0);
        @(negedge pclk);
        chk("b2b ready last", pready[0], 1);
        @(posedge pclk); #1;
        commit(0, 8'd2, b2b_data[2]);
        @(posedge pclk); #1;

        // Abort: psel dropped during a wait state.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'd7; pwdata[1] = 24'hDEAD01;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("abort wait pready", pready[1], 0);
        @(posedge pclk); #1;
        bus_idle(1);
        @(posedge pclk); #1;
        exp_perr[1] = 1'b1;
        xfer(1, 1'b0, 8'd7, 24'h0, w, rd, e);
        chk("abort reg7 preserved", rd, mreg[1][7]);

        // Penable without a preceding setup cycle.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'd3; pwdata[0] = 24'h777777;
        @(posedge pclk); #1;
        bus_idle(0);
        exp_perr[0] = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("penable-only proto_err", perr[0], 1);

        // Asynchronous reset in the middle of a waited write to reg9.
        @(posedge pclk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'd9; pwdata[1] = 24'h999999;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #2;
        reset = 1'b1;
        model_clear();
        bus_idle(0); bus_idle(1);
        #1 reset_state_checks("async");
        @(posedge pclk); #3;
        reset = 1'b0;
        @(posedge pclk); #1;
        xfer(1, 1'b0, 8'd9, 24'h0, w, rd, e);
        chk("reset dropped write", rd, 24'h0);
        xfer(0, 1'b1, 8'd57, 24'h00C0DE, w, rd, e);
        xfer(0, 1'b0, 8'd57, 24'h0, w, rd, e);
        chk("post-reset reg57", rd, 24'h00C0DE);
        @(posedge pclk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
